mips_timer: RTL

- Memory-mapped countdown timer on the CPU bridge.
- Its interrupt output drives HWInt[0] of the coprocessor-0 exception unit.
- Software loads PRESET, then enables the timer through CTRL. The timer counts down to zero and raises IRQ.
- IRQ is either held (one-shot mode) or pulsed with automatic reload (periodic mode).

---
 rtl/mips_timer.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/mips_timer.sv
// -----------------------------------------------------------------------------
// mips_timer
//
// Memory-mapped countdown timer on the CPU bridge. Software loads PRESET and
// enables the timer through CTRL. The timer reloads COUNT from PRESET, counts
// down to zero and raises an interrupt. The interrupt is held in one-shot mode
// and is a one-cycle pulse with automatic reload in periodic mode. irq drives
// HWInt[0] of the coprocessor-0 exception unit.
//
// Register map (addr[3:2]):
//   0 CTRL   [0] EN, [2:1] MODE (01 periodic, else one-shot), [3] IM
//            [7:4] P (prescale limit, only with TIMER_PRESCALE_EN)
//   1 PRESET reload value
//   2 COUNT  live count, read-only
//   3 --     reads 0, writes ignored
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous active-high reset
//   we     in   bus write enable
//   addr   in   byte address, only addr[3:2] decoded
//   din    in   bus write data
//   dout   out  bus read data (combinational)
//   irq    out  interrupt request, CTRL.IM & internal irq flag
//
// Optional feature macro: TIMER_PRESCALE_EN
//   When defined, CTRL[7:4] = P is a prescale limit; in CNT the count only
//   advances once every P+1 cycles. When undefined, CTRL[7:4] reads 0 and the
//   count advances every CNT cycle.
// -----------------------------------------------------------------------------
module mips_timer #(
  parameter logic [31:0] INIT_PRESET = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_PRESET = 2'd1,
    REG_COUNT  = 2'd2,
    REG_NONE   = 2'd3
  } reg_sel_e;

  localparam logic [1:0] MODE_PERIODIC = 2'b01;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e      state_q,    state_d;
  logic        en_q,       en_d;
  logic [1:0]  mode_q,     mode_d;
  logic        im_q,       im_d;
  logic [31:0] preset_q,   preset_d;
  logic [31:0] count_q,    count_d;
  logic        irq_flag_q, irq_flag_d;

  reg_sel_e    sel;
  logic        cfg_write;   // write to CTRL or PRESET: restarts the sequence
  logic        tick;        // count may advance this CNT cycle
  logic [3:0]  ctrl_p;      // CTRL[7:4] as seen on reads

`ifdef TIMER_PRESCALE_EN
  logic [3:0]  psc_lim_q, psc_lim_d;
  logic [3:0]  psc_q,     psc_d;

  assign tick   = (psc_q == psc_lim_q);
  assign ctrl_p = psc_lim_q;
`else
  assign tick   = 1'b1;
  assign ctrl_p = 4'h0;
`endif

  assign sel       = reg_sel_e'(addr[3:2]);
  assign cfg_write = we && ((sel == REG_CTRL) || (sel == REG_PRESET));

  // Only addr[3:2] is decoded and only the low CTRL bits are stored.
  logic unused_bits;
`ifdef TIMER_PRESCALE_EN
  assign unused_bits = ^{addr[31:4], addr[1:0], din[31:8]};
`else
  assign unused_bits = ^{addr[31:4], addr[1:0], din[31:4]};
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: every register here is a small control/data flop, so all of them get
  // an asynchronous reset value; sequential state is only ever assigned with
  // non-blocking assignments so that all flops sample the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      en_q       <= 1'b0;
      mode_q     <= 2'b00;
      im_q       <= 1'b0;
      preset_q   <= INIT_PRESET;
      count_q    <= 32'h0;
      irq_flag_q <= 1'b0;
`ifdef TIMER_PRESCALE_EN
      psc_lim_q  <= 4'h0;
      psc_q      <= 4'h0;
`endif
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      mode_q     <= mode_d;
      im_q       <= im_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
`ifdef TIMER_PRESCALE_EN
      psc_lim_q  <= psc_lim_d;
      psc_q      <= psc_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: FSM step first, then a CTRL/PRESET bus write overrides it
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable starts from its hold value so that no path through
    // the case statements leaves one unassigned (which would infer a latch).
    state_d    = state_q;
    en_d       = en_q;
    mode_d     = mode_q;
    im_d       = im_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;
`ifdef TIMER_PRESCALE_EN
    psc_lim_d  = psc_lim_q;
    psc_d      = psc_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (en_q) state_d = ST_LOAD;
      end

      ST_LOAD: begin
        count_d = preset_q;
`ifdef TIMER_PRESCALE_EN
        psc_d   = 4'h0;
`endif
        state_d = ST_CNT;
      end

      ST_CNT: begin
        if (!en_q) begin
          // Disable freezes COUNT; re-enabling goes through LOAD again.
          state_d = ST_IDLE;
        end else begin
`ifdef TIMER_PRESCALE_EN
          psc_d = tick ? 4'h0 : psc_q + 4'h1;
`endif
          if (tick) begin
            // Zero is terminal: the count never wraps below it.
            if (count_q != 32'h0) begin
              count_d = count_q - 32'h1;
            end else begin
              irq_flag_d = 1'b1;
              state_d    = ST_INT;
            end
          end
        end
      end

      ST_INT: begin
        if (mode_q == MODE_PERIODIC) begin
          // Drop the flag after one cycle; EN stays set, so IDLE reloads.
          irq_flag_d = 1'b0;
        end else begin
          // One-shot: keep the flag asserted and stop the timer.
          en_d = 1'b0;
        end
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // A configuration write wins over whatever the FSM did this cycle,
    // including any COUNT update.
    if (cfg_write) begin
      state_d    = ST_IDLE;
      irq_flag_d = 1'b0;
      count_d    = count_q;
`ifdef TIMER_PRESCALE_EN
      psc_d      = 4'h0;
`endif
      if (sel == REG_CTRL) begin
        en_d      = din[0];
        mode_d    = din[2:1];
        im_d      = din[3];
`ifdef TIMER_PRESCALE_EN
        psc_lim_d = din[7:4];
`endif
      end else begin
        // PRESET only takes effect at the next LOAD.
        preset_d = din;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: read mux and masked interrupt
  // ---------------------------------------------------------------------------
  always_comb begin
    dout = 32'h0;
    unique case (sel)
      REG_CTRL:   dout = {24'h0, ctrl_p, im_q, mode_q, en_q};
      REG_PRESET: dout = preset_q;
      REG_COUNT:  dout = count_q;
      REG_NONE:   dout = 32'h0;
      default:    dout = 32'h0;
    endcase

    irq = im_q & irq_flag_q;
  end

endmodule
